// File: rtl/aes_inv_round_ctrl.sv
// Sequencer for an external AES-128 inverse-round datapath: walks InvShiftRows/InvSubBytes/
// AddRoundKey/InvMixColumns over 10 rounds. Optional abort port under macro INV_CTRL_ABORT_EN.
module aes_inv_round_ctrl #(
    parameter int DATA_W = 128
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] cipher_in,
    output logic [DATA_W-1:0] dp_state,
    output logic [1:0]        dp_op,
    input  logic [DATA_W-1:0] dp_result,
    output logic [3:0]        key_idx,
    output logic              busy,
    output logic              out_valid,
    input  logic              out_ack
`ifdef INV_CTRL_ABORT_EN
    ,
    input  logic              abort
`endif
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] INIT  = 3'd1;
    localparam logic [2:0] ROUND = 3'd2;
    localparam logic [2:0] FINAL = 3'd3;
    localparam logic [2:0] DONE  = 3'd4;

    localparam logic [1:0] OP_ARK = 2'd0;
    localparam logic [1:0] OP_ISR = 2'd1;
    localparam logic [1:0] OP_ISB = 2'd2;
    localparam logic [1:0] OP_IMC = 2'd3;

    logic [2:0]        state;
    logic [1:0]        step;
    logic [3:0]        round;
    logic [DATA_W-1:0] st_reg;
    logic              abort_req;

    assign busy      = (state == INIT) || (state == ROUND) || (state == FINAL);
    assign out_valid = (state == DONE);
    assign dp_state  = st_reg;

`ifdef INV_CTRL_ABORT_EN
    assign abort_req = abort && busy;
`else
    assign abort_req = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst || abort_req) begin
            state  <= IDLE;
            step   <= 2'd0;
            round  <= 4'd0;
            st_reg <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        st_reg <= cipher_in;
                        round  <= 4'd9;
                        step   <= 2'd0;
                        state  <= INIT;
                    end
                end
                INIT: begin
                    st_reg <= dp_result;
                    step   <= 2'd0;
                    state  <= ROUND;
                end
                ROUND: begin
                    st_reg <= dp_result;
                    if (step == 2'd3) begin
                        step <= 2'd0;
                        if (round > 4'd1) begin
                            round <= round - 4'd1;
                        end else begin
                            state <= FINAL;
                        end
                    end else begin
                        step <= step + 2'd1;
                    end
                end
                FINAL: begin
                    st_reg <= dp_result;
                    if (step == 2'd2) begin
                        step  <= 2'd0;
                        state <= DONE;
                    end else begin
                        step <= step + 2'd1;
                    end
                end
                DONE: begin
                    // start alongside out_ack is deliberately dropped; IDLE must see it again
                    if (out_ack) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // The last round has no InvMixColumns, so FINAL only cycles through three steps
    always_comb begin
        dp_op   = OP_ARK;
        key_idx = 4'd0;
        case (state)
            INIT: begin
                key_idx = 4'd10;
            end
            ROUND: begin
                key_idx = round;
                case (step)
                    2'd0:    dp_op = OP_ISR;
                    2'd1:    dp_op = OP_ISB;
                    2'd2:    dp_op = OP_ARK;
                    default: dp_op = OP_IMC;
                endcase
            end
            FINAL: begin
                case (step)
                    2'd0:    dp_op = OP_ISR;
                    2'd1:    dp_op = OP_ISB;
                    default: dp_op = OP_ARK;
                endcase
            end
            default: begin
                dp_op   = OP_ARK;
                key_idx = 4'd0;
            end
        endcase
    end

endmodule

// File: tb/tb_aes_inv_round_ctrl.sv
// Bench for aes_inv_round_ctrl with a behavioural AES-128 inverse datapath and key store.
// Define INV_CTRL_ABORT_EN for both files to exercise the abort port.
module tb_aes_inv_round_ctrl;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [127:0] cipher_in;
    logic [127:0] dp_state;
    logic [1:0]   dp_op;
    logic [127:0] dp_result;
    logic [3:0]   key_idx;
    logic         busy;
    logic         out_valid;
    logic         out_ack;
`ifdef INV_CTRL_ABORT_EN
    logic         abort;
`endif

    int checks = 0;
    int errors = 0;
    int op_n   = 0;

    localparam logic [127:0] KEY   = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] CT0   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] PT0   = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] OTHER = 128'h0123456789abcdeffedcba9876543210;

    typedef struct {
        logic [1:0] op;
        logic [3:0] key;
    } seq_t;

    typedef struct {
        logic [127:0] cipher;
        logic [127:0] plain;
    } vec_t;

    seq_t         seq_tab[40];
    vec_t         vec_tab[2];
    logic [7:0]   sbox[256];
    logic [7:0]   isbox[256];
    logic [127:0] rk[11];

    aes_inv_round_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .cipher_in (cipher_in),
        .dp_state  (dp_state),
        .dp_op     (dp_op),
        .dp_result (dp_result),
        .key_idx   (key_idx),
        .busy      (busy),
        .out_valid (out_valid),
        .out_ack   (out_ack)
`ifdef INV_CTRL_ABORT_EN
        ,
        .abort     (abort)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] p;
        a = a_in;
        b = b_in;
        p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        return (v << n) | (v >> (8 - n));
    endfunction

    function automatic logic [7:0] byte_of(input logic [127:0] s, input int i);
        return s[127 - 8 * i -: 8];
    endfunction

    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127 - 8 * (r + 4 * c) -: 8] = byte_of(s, r + 4 * ((c - r + 4) % 4));
        return o;
    endfunction

    function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int i = 0; i < 16; i++) o[127 - 8 * i -: 8] = isbox[byte_of(s, i)];
        return o;
    endfunction

    function automatic logic [127:0] inv_mix(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = byte_of(s, 4 * c);
            a1 = byte_of(s, 4 * c + 1);
            a2 = byte_of(s, 4 * c + 2);
            a3 = byte_of(s, 4 * c + 3);
            o[127 - 32 * c -: 32] = {
                gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09),
                gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d),
                gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b),
                gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e)};
        end
        return o;
    endfunction

    function automatic logic [127:0] aes_dec(input logic [127:0] c);
        logic [127:0] s;
        s = c ^ rk[10];
        for (int r = 9; r >= 1; r--)
            s = inv_mix(inv_sub_bytes(inv_shift_rows(s)) ^ rk[r]);
        return inv_sub_bytes(inv_shift_rows(s)) ^ rk[0];
    endfunction

    // Behavioural datapath and key store
    always_comb begin
        case (dp_op)
            2'd1:    dp_result = inv_shift_rows(dp_state);
            2'd2:    dp_result = inv_sub_bytes(dp_state);
            2'd3:    dp_result = inv_mix(dp_state);
            default: dp_result = dp_state ^ ((int'(key_idx) <= 10) ? rk[int'(key_idx)] : 128'h0);
        endcase
    end

    task automatic build_tables();
        logic [7:0]  inv;
        logic [7:0]  x;
        logic [31:0] w[44];
        logic [31:0] t;
        logic [7:0]  rc;
        for (int v = 0; v < 256; v++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(v), 8'(y)) == 8'h01) inv = 8'(y);
            x = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
            sbox[v] = x;
        end
        for (int v = 0; v < 256; v++) isbox[sbox[v]] = 8'(v);
        for (int i = 0; i < 4; i++) w[i] = KEY[127 - 32 * i -: 32];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            t = w[i - 1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]} ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i - 4] ^ t;
        end
        for (int r = 0; r < 11; r++) rk[r] = {w[4 * r], w[4 * r + 1], w[4 * r + 2], w[4 * r + 3]};
    endtask

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic accept(input logic [127:0] ct);
        start     = 1'b1;
        cipher_in = ct;
        tick();
        start     = 1'b0;
        op_n      = 0;
    endtask

    // Check busy/op/key before each op edge; optionally poke start or out_ack mid-run
    task automatic op_cycles(input int n, input int glitch_at, input logic ack_during);
        for (int k = 0; k < n; k++) begin
            chk($sformatf("op[%0d] {busy,op,key}", op_n), {121'h0, busy, dp_op, key_idx},
                {121'h0, 1'b1, seq_tab[op_n].op, seq_tab[op_n].key});
            start     = (k == glitch_at);
            cipher_in = (k == glitch_at) ? OTHER : cipher_in;
            out_ack   = ack_during;
            tick();
            op_n++;
        end
        start   = 1'b0;
        out_ack = 1'b0;
    endtask

    task automatic finish_check(input string name, input logic [127:0] exp);
        chk({name, " busy after 40 ops"}, {127'h0, busy}, 128'h0);
        chk({name, " out_valid after 40 ops"}, {127'h0, out_valid}, 128'h1);
        chk({name, " plaintext"}, dp_state, exp);
    endtask

    task automatic ack_done();
        out_ack = 1'b1;
        tick();
        out_ack = 1'b0;
        chk("ack -> idle", {126'h0, busy, out_valid}, 128'h0);
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        cipher_in = '0;
        out_ack   = 1'b0;
`ifdef INV_CTRL_ABORT_EN
        abort     = 1'b0;
`endif
        build_tables();

        seq_tab[0] = '{2'd0, 4'd10};
        for (int r = 9; r >= 1; r--) begin
            seq_tab[(9 - r) * 4 + 1] = '{2'd1, 4'(r)};
            seq_tab[(9 - r) * 4 + 2] = '{2'd2, 4'(r)};
            seq_tab[(9 - r) * 4 + 3] = '{2'd0, 4'(r)};
            seq_tab[(9 - r) * 4 + 4] = '{2'd3, 4'(r)};
        end
        seq_tab[37] = '{2'd1, 4'd0};
        seq_tab[38] = '{2'd2, 4'd0};
        seq_tab[39] = '{2'd0, 4'd0};
        vec_tab[0] = '{CT0, PT0};
        vec_tab[1] = '{OTHER, aes_dec(OTHER)};

        chk("model decrypts reference vector", aes_dec(CT0), PT0);

        tick();
        tick();
        chk("reset {busy,out_valid,op,key}", {121'h0, busy, out_valid, dp_op, key_idx}, 128'h0);
        chk("reset dp_state", dp_state, 128'h0);
        rst = 1'b0;

        // out_ack in IDLE is ignored
        out_ack = 1'b1;
        tick();
        out_ack = 1'b0;
        chk("out_ack in idle ignored", {126'h0, busy, out_valid}, 128'h0);

        for (int v = 0; v < 2; v++) begin
            accept(vec_tab[v].cipher);
            op_cycles(39, -1, 1'b0);
            chk($sformatf("vec%0d out_valid before edge 40", v), {127'h0, out_valid}, 128'h0);
            op_cycles(1, -1, 1'b0);
            finish_check($sformatf("vec%0d", v), vec_tab[v].plain);
            ack_done();
        end

        // Handshake: result held while unacknowledged; start with ack is dropped
        accept(CT0);
        op_cycles(40, -1, 1'b0);
        for (int k = 0; k < 20; k++) tick();
        chk("held out_valid", {127'h0, out_valid}, 128'h1);
        chk("held dp_state", dp_state, PT0);
        start   = 1'b1;
        out_ack = 1'b1;
        cipher_in = OTHER;
        tick();
        start   = 1'b0;
        out_ack = 1'b0;
        chk("ack+start -> idle", {126'h0, busy, out_valid}, 128'h0);
        tick();
        chk("no new block from start with ack", {126'h0, busy, out_valid}, 128'h0);
        chk("state untouched by dropped start", dp_state, PT0);

        // Ignored start at op cycle 15 plus out_ack while busy
        accept(CT0);
        op_cycles(40, 15, 1'b1);
        finish_check("ignored start", PT0);
        ack_done();

        // Reset mid-run
        accept(CT0);
        op_cycles(22, -1, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid-run reset {busy,out_valid,key}", {123'h0, busy, out_valid, key_idx}, 128'h0);
        chk("mid-run reset dp_state", dp_state, 128'h0);
        accept(CT0);
        op_cycles(40, -1, 1'b0);
        finish_check("after reset", PT0);

        // Reset outranks out_ack and start in DONE
        rst     = 1'b1;
        out_ack = 1'b1;
        start   = 1'b1;
        tick();
        rst     = 1'b0;
        out_ack = 1'b0;
        start   = 1'b0;
        chk("rst beats start {busy,out_valid}", {126'h0, busy, out_valid}, 128'h0);
        chk("rst beats start dp_state", dp_state, 128'h0);

`ifdef INV_CTRL_ABORT_EN
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort in idle ignored", {126'h0, busy, out_valid}, 128'h0);

        accept(CT0);
        op_cycles(30, -1, 1'b0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort {busy,out_valid}", {126'h0, busy, out_valid}, 128'h0);
        chk("abort dp_state", dp_state, 128'h0);
        begin
            logic seen;
            seen = 1'b0;
            for (int k = 0; k < 45; k++) begin
                seen = seen | out_valid;
                tick();
            end
            chk("out_valid never after abort", {127'h0, seen}, 128'h0);
        end

        accept(CT0);
        op_cycles(40, -1, 1'b0);
        abort = 1'b1;
        tick();
        tick();
        abort = 1'b0;
        chk("abort in done out_valid", {127'h0, out_valid}, 128'h1);
        chk("abort in done dp_state", dp_state, PT0);
        ack_done();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
